gumnut_core: RTL and testbench

GUMNUT_CORE -- requirements
Module: gumnut_core

---
 rtl/gumnut_pkg.sv | 61 ++++++
 rtl/gumnut_alu.sv | 75 +++++++
 rtl/gumnut_core.sv | 221 ++++++++++++++++++++++
 tb/tb_gumnut_core.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_pkg.sv
// gumnut_pkg: shared types and opcode field constants for the Gumnut core.
//   state_e      - instruction sequencer states
//   alu_fn_e     - ALU function codes (immediate and register forms)
//   shift_fn_e   - shifter function codes
//   mem_fn_e     - memory / I/O function codes
//   branch_fn_e  - conditional branch codes
//   misc_fn_e    - miscellaneous instruction codes
//   OP_*         - opcode prefixes, compared against the top bits of IR
package gumnut_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_MEM     = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDC = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_SUBC = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_MASK = 3'd7
    } alu_fn_e;

    typedef enum logic [1:0] {
        SH_SHL = 2'd0,
        SH_SHR = 2'd1,
        SH_ROL = 2'd2,
        SH_ROR = 2'd3
    } shift_fn_e;

    typedef enum logic [1:0] {
        MEM_LDM = 2'd0,
        MEM_STM = 2'd1,
        MEM_INP = 2'd2,
        MEM_OUT = 2'd3
    } mem_fn_e;

    typedef enum logic [1:0] {
        BR_BZ  = 2'd0,
        BR_BNZ = 2'd1,
        BR_BC  = 2'd2,
        BR_BNC = 2'd3
    } branch_fn_e;

    typedef enum logic [2:0] {
        MISC_RET = 3'd0
    } misc_fn_e;

    // Opcode prefixes (IR[17] == 0 is the ALU-immediate class).
    localparam logic [3:0] OP_ALU_REG = 4'b1110;    // IR[17:14]
    localparam logic [2:0] OP_SHIFT   = 3'b110;     // IR[17:15]
    localparam logic [1:0] OP_MEM     = 2'b10;      // IR[17:16]
    localparam logic [5:0] OP_BRANCH  = 6'b111110;  // IR[17:12]
    localparam logic [4:0] OP_JUMP    = 5'b11110;   // IR[17:13]
    localparam logic [6:0] OP_MISC    = 7'b1111110; // IR[17:11]

endpackage

// File: rtl/gumnut_alu.sv
// gumnut_alu: combinational ALU and shifter.
//   a_i, b_i    - 8-bit operands (b_i unused by the shifter)
//   shift_i     - 1 selects the shifter, 0 the ALU
//   alu_fn_i    - ALU function
//   shift_fn_i  - shifter function, count_i - shift distance 0..7
//   c_i         - carry/borrow in for addc/subc
//   result_o    - 8-bit result, z_o - result is zero, c_o - carry/borrow/last bit out
module gumnut_alu
    import gumnut_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       shift_i,
    input  alu_fn_e    alu_fn_i,
    input  shift_fn_e  shift_fn_i,
    input  logic [2:0] count_i,
    input  logic       c_i,
    output logic [7:0] result_o,
    output logic       z_o,
    output logic       c_o
);

    logic [8:0]  arith;
    logic [15:0] t_left;
    logic [15:0] t_right;

    always_comb begin
        result_o = 8'h00;
        c_o      = 1'b0;
        arith    = 9'h000;
        // Shifting into a double-width word leaves the last bit shifted out
        // sitting just beyond the result byte; with count 0 that bit is 0.
        t_left   = {8'h00, a_i} << count_i;
        t_right  = {a_i, 8'h00} >> count_i;
        if (shift_i) begin
            unique case (shift_fn_i)
                SH_SHL: begin
                    result_o = t_left[7:0];
                    c_o      = t_left[8];
                end
                SH_SHR: begin
                    result_o = t_right[15:8];
                    c_o      = t_right[7];
                end
                SH_ROL: begin
                    result_o = t_left[7:0] | t_left[15:8];
                    c_o      = (count_i != 3'd0) && result_o[0];
                end
                SH_ROR: begin
                    result_o = t_right[15:8] | t_right[7:0];
                    c_o      = (count_i != 3'd0) && result_o[7];
                end
                default: ;
            endcase
        end else begin
            unique case (alu_fn_i)
                ALU_ADD:  arith = {1'b0, a_i} + {1'b0, b_i};
                ALU_ADDC: arith = {1'b0, a_i} + {1'b0, b_i} + {8'h00, c_i};
                // Bit 8 of the 9-bit difference is the borrow.
                ALU_SUB:  arith = {1'b0, a_i} - {1'b0, b_i};
                ALU_SUBC: arith = {1'b0, a_i} - {1'b0, b_i} - {8'h00, c_i};
                ALU_AND:  arith = {1'b0, a_i & b_i};
                ALU_OR:   arith = {1'b0, a_i | b_i};
                ALU_XOR:  arith = {1'b0, a_i ^ b_i};
                ALU_MASK: arith = {1'b0, a_i & ~b_i};
                default: ;
            endcase
            result_o = arith[7:0];
            c_o      = arith[8];
        end
    end

    assign z_o = (result_o == 8'h00);

endmodule

// File: rtl/gumnut_core.sv
// gumnut_core: multi-cycle Gumnut processor (FETCH -> EXECUTE -> [MEM]).
//   clk_i, rst_i                    - clock, synchronous active-high reset
//   inst_*                          - instruction bus (12-bit address, 18-bit word)
//   data_*                          - data memory bus (ldm/stm)
//   port_*                          - I/O bus (inp/out), same handshake as data bus
//   int_req, int_ack                - interrupts are not supported; int_ack is 0
//   debug                           - when 1, prints each executed instruction
module gumnut_core
    import gumnut_pkg::*;
#(
    parameter logic debug = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        inst_cyc_o,
    output logic        inst_stb_o,
    input  logic        inst_ack_i,
    output logic [11:0] inst_adr_o,
    input  logic [17:0] inst_dat_i,
    output logic        data_cyc_o,
    output logic        data_stb_o,
    output logic        data_we_o,
    input  logic        data_ack_i,
    output logic [7:0]  data_adr_o,
    output logic [7:0]  data_dat_o,
    input  logic [7:0]  data_dat_i,
    output logic        port_cyc_o,
    output logic        port_stb_o,
    output logic        port_we_o,
    input  logic        port_ack_i,
    output logic [7:0]  port_adr_o,
    output logic [7:0]  port_dat_o,
    input  logic [7:0]  port_dat_i,
    input  logic        int_req,
    output logic        int_ack
);

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [17:0] ir_q, ir_d;
    logic        z_q, z_d, c_q, c_d;
    logic [2:0]  sp_q, sp_d;
    logic [7:0]  GPR [0:7];
    logic [11:0] stack_q [0:7];

    logic        gpr_we, stack_push;
    logic [7:0]  gpr_wdata;

    // Instruction fields and register reads (r0 is never written, so it reads 0).
    logic [2:0]  rd_idx, rs_idx, r2_idx;
    logic [7:0]  imm, rs_val, rd_val, r2_val, mem_adr, mem_rdata;
    logic [11:0] pc_inc, br_target, ret_adr;
    assign rd_idx    = ir_q[13:11];
    assign rs_idx    = ir_q[10:8];
    assign r2_idx    = ir_q[7:5];
    assign imm       = ir_q[7:0];
    assign rs_val    = GPR[rs_idx];
    assign rd_val    = GPR[rd_idx];
    assign r2_val    = GPR[r2_idx];
    assign mem_adr   = rs_val + imm;
    assign pc_inc    = pc_q + 12'd1;
    assign br_target = pc_inc + {{4{imm[7]}}, imm};
    assign ret_adr   = stack_q[sp_q - 3'd1];

    logic is_alu_imm, is_alu_reg, is_shift, is_mem, is_branch, is_jump, is_misc;
    assign is_alu_imm = ~ir_q[17];
    assign is_alu_reg = (ir_q[17:14] == OP_ALU_REG);
    assign is_shift   = (ir_q[17:15] == OP_SHIFT);
    assign is_mem     = (ir_q[17:16] == OP_MEM);
    assign is_branch  = (ir_q[17:12] == OP_BRANCH);
    assign is_jump    = (ir_q[17:13] == OP_JUMP);
    assign is_misc    = (ir_q[17:11] == OP_MISC);

    mem_fn_e mem_fn;
    logic    mem_port, mem_write, mem_ack;
    assign mem_fn    = mem_fn_e'(ir_q[15:14]);
    assign mem_port  = (mem_fn == MEM_INP) || (mem_fn == MEM_OUT);
    assign mem_write = (mem_fn == MEM_STM) || (mem_fn == MEM_OUT);
    assign mem_ack   = mem_port ? port_ack_i : data_ack_i;
    assign mem_rdata = mem_port ? port_dat_i : data_dat_i;

    logic [7:0] alu_result;
    logic       alu_z, alu_c;

    gumnut_alu u_alu (
        .a_i        (rs_val),
        .b_i        (is_alu_imm ? imm : r2_val),
        .shift_i    (is_shift),
        .alu_fn_i   (alu_fn_e'(is_alu_imm ? ir_q[16:14] : ir_q[2:0])),
        .shift_fn_i (shift_fn_e'(ir_q[1:0])),
        .count_i    (ir_q[7:5]),
        .c_i        (c_q),
        .result_o   (alu_result),
        .z_o        (alu_z),
        .c_o        (alu_c)
    );

    logic branch_taken;
    always_comb begin
        branch_taken = 1'b0;
        unique case (branch_fn_e'(ir_q[11:10]))
            BR_BZ:   branch_taken = z_q;
            BR_BNZ:  branch_taken = ~z_q;
            BR_BC:   branch_taken = c_q;
            BR_BNC:  branch_taken = ~c_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        z_d        = z_q;
        c_d        = c_q;
        sp_d       = sp_q;
        gpr_we     = 1'b0;
        gpr_wdata  = alu_result;
        stack_push = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (inst_ack_i) begin
                    ir_d    = inst_dat_i;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                if (is_alu_imm || is_alu_reg || is_shift) begin
                    gpr_we = 1'b1;
                    z_d    = alu_z;
                    c_d    = alu_c;
                end else if (is_mem) begin
                    // PC advances only once the bus transfer completes.
                    state_d = ST_MEM;
                    pc_d    = pc_q;
                end else if (is_branch) begin
                    if (branch_taken) pc_d = br_target;
                end else if (is_jump) begin
                    pc_d       = ir_q[11:0];
                    stack_push = ir_q[12];
                    if (ir_q[12]) sp_d = sp_q + 3'd1;
                end else if (is_misc && (misc_fn_e'(ir_q[10:8]) == MISC_RET)) begin
                    pc_d = ret_adr;
                    sp_d = sp_q - 3'd1;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    gpr_we    = ~mem_write;
                    gpr_wdata = mem_rdata;
                    pc_d      = pc_inc;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // The return stack is cleared with everything else so a ret without a
    // matching jsb always lands at a deterministic address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
            pc_q    <= 12'h000;
            ir_q    <= 18'h00000;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            sp_q    <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                GPR[i]     <= 8'h00;
                stack_q[i] <= 12'h000;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
            sp_q    <= sp_d;
            if (gpr_we && (rd_idx != 3'd0)) GPR[rd_idx] <= gpr_wdata;
            if (stack_push) stack_q[sp_q] <= pc_inc;
        end
    end

    // The fetch strobe is masked while reset is held so that every bus
    // strobe is low for as long as rst_i is asserted.
    logic in_mem;
    assign in_mem     = (state_q == ST_MEM);
    assign inst_cyc_o = (state_q == ST_FETCH) && !rst_i;
    assign inst_stb_o = inst_cyc_o;
    assign inst_adr_o = pc_q;

    assign data_cyc_o = in_mem && !mem_port;
    assign data_stb_o = data_cyc_o;
    assign data_we_o  = data_cyc_o && mem_write;
    assign data_adr_o = data_cyc_o ? mem_adr : 8'h00;
    assign data_dat_o = data_cyc_o ? rd_val : 8'h00;

    assign port_cyc_o = in_mem && mem_port;
    assign port_stb_o = port_cyc_o;
    assign port_we_o  = port_cyc_o && mem_write;
    assign port_adr_o = port_cyc_o ? mem_adr : 8'h00;
    assign port_dat_o = port_cyc_o ? rd_val : 8'h00;

    assign int_ack = 1'b0;
    logic unused_int_req;
    assign unused_int_req = int_req;

    generate
        if (debug) begin : g_debug
            always_ff @(posedge clk_i) begin
                if (!rst_i && (state_q == ST_EXECUTE))
                    $display("gumnut: pc=%03h ir=%05h we=%0d r%0d<=%02h z=%0d c=%0d pc_next=%03h",
                             pc_q, ir_q, gpr_we, rd_idx, gpr_wdata, z_d, c_d, pc_d);
            end
        end
    endgenerate

endmodule

// File: tb/tb_gumnut_core.sv
// tb_gumnut_core: scoreboard bench for gumnut_core. A reference instruction-set
// model executes the program in imem and queues the expected bus transactions;
// a monitor pops and compares each acknowledged DUT bus transaction.
module tb_gumnut_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        inst_cyc_o, inst_stb_o, inst_ack_i;
    logic [11:0] inst_adr_o;
    logic [17:0] inst_dat_i;
    logic        data_cyc_o, data_stb_o, data_we_o, data_ack_i;
    logic [7:0]  data_adr_o, data_dat_o, data_dat_i;
    logic        port_cyc_o, port_stb_o, port_we_o, port_ack_i;
    logic [7:0]  port_adr_o, port_dat_o, port_dat_i;
    logic        int_req, int_ack;

    logic        inst_gate, data_gate, port_gate, stall_en;
    logic [17:0] imem [0:4095];
    logic [7:0]  dmem [0:255];

    function automatic logic [7:0] port_rd(input logic [7:0] a);
        return 8'(a * 7 + 3);
    endfunction

    assign inst_ack_i = inst_cyc_o & inst_stb_o & inst_gate;
    assign inst_dat_i = imem[inst_adr_o];
    assign data_ack_i = data_cyc_o & data_stb_o & data_gate;
    assign data_dat_i = dmem[data_adr_o];
    assign port_ack_i = port_cyc_o & port_stb_o & port_gate;
    assign port_dat_i = port_rd(port_adr_o);

    gumnut_core #(.debug(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_ack_i(inst_ack_i),
        .inst_adr_o(inst_adr_o), .inst_dat_i(inst_dat_i),
        .data_cyc_o(data_cyc_o), .data_stb_o(data_stb_o), .data_we_o(data_we_o),
        .data_ack_i(data_ack_i), .data_adr_o(data_adr_o), .data_dat_o(data_dat_o),
        .data_dat_i(data_dat_i),
        .port_cyc_o(port_cyc_o), .port_stb_o(port_stb_o), .port_we_o(port_we_o),
        .port_ack_i(port_ack_i), .port_adr_o(port_adr_o), .port_dat_o(port_dat_o),
        .port_dat_i(port_dat_i),
        .int_req(int_req), .int_ack(int_ack)
    );

    always @(posedge clk)
        if (data_cyc_o && data_stb_o && data_we_o && data_ack_i) dmem[data_adr_o] <= data_dat_o;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #2;
        if (stall_en) begin
            inst_gate = ($urandom_range(0, 3) != 0);
            data_gate = ($urandom_range(0, 2) != 0);
            port_gate = ($urandom_range(0, 2) != 0);
        end
    end

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end else begin
            $display("check %s: 0x%0h", nm, act);
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]  kind;   // 0 fetch, 1 data bus, 2 port bus
        logic [11:0] adr;
        logic        we;
        logic [7:0]  dat;    // write data only; 0 for reads
    } ev_t;

    ev_t exp_q[$];
    int  fetch_log[$];
    int  fetch_cyc[$];
    int  wr_count, last_wr_adr, last_wr_dat;

    always @(negedge clk) begin
        ev_t act;
        ev_t e;
        logic have;
        have = 1'b0;
        act  = '0;
        if (inst_cyc_o && inst_stb_o && inst_ack_i) begin
            act.kind = 2'd0; act.adr = inst_adr_o; have = 1'b1;
            fetch_log.push_back(int'(inst_adr_o));
            fetch_cyc.push_back(cycle);
        end else if (data_cyc_o && data_stb_o && data_ack_i) begin
            act.kind = 2'd1; act.adr = {4'h0, data_adr_o}; act.we = data_we_o;
            act.dat  = data_we_o ? data_dat_o : 8'h00; have = 1'b1;
            if (data_we_o) begin
                wr_count++; last_wr_adr = data_adr_o; last_wr_dat = data_dat_o;
            end
        end else if (port_cyc_o && port_stb_o && port_ack_i) begin
            act.kind = 2'd2; act.adr = {4'h0, port_adr_o}; act.we = port_we_o;
            act.dat  = port_we_o ? port_dat_o : 8'h00; have = 1'b1;
        end
        if (have && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("bus_event{kind,adr,we,dat}", int'(act), int'(e));
        end
    end

    // ---------------- reference model ----------------
    int m_pc, m_z, m_c, m_sp;
    int m_r [8];
    int m_stack [8];
    int m_dmem [256];

    task automatic push_ev(input int kind, input int adr, input int we, input int dat);
        ev_t e;
        e.kind = 2'(kind); e.adr = 12'(adr); e.we = we[0]; e.dat = 8'(dat);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_pc = 0; m_z = 0; m_c = 0; m_sp = 0;
        for (int i = 0; i < 8; i++) begin m_r[i] = 0; m_stack[i] = 0; end
        for (int i = 0; i < 256; i++) m_dmem[i] = dmem[i];
    endtask

    task automatic model_step();
        logic [17:0] ir;
        int a, b, s, r, npc, adr, fn, disp, wr, rd, taken;
        ir  = imem[m_pc];
        push_ev(0, m_pc, 0, 0);
        npc = (m_pc + 1) % 4096;
        rd  = ir[13:11];
        a   = m_r[ir[10:8]];
        wr  = 0;
        r   = 0;
        if (ir[17] == 1'b0 || ir[17:14] == 4'b1110) begin
            fn = ir[17] ? int'(ir[2:0]) : int'(ir[16:14]);
            b  = ir[17] ? m_r[ir[7:5]] : int'(ir[7:0]);
            case (fn)
                0: s = a + b;
                1: s = a + b + m_c;
                2: s = a - b;
                3: s = a - b - m_c;
                4: s = a & b;
                5: s = a | b;
                6: s = a ^ b;
                default: s = a & ~b & 255;
            endcase
            if (fn < 2) m_c = (s > 255) ? 1 : 0;
            else if (fn < 4) m_c = (s < 0) ? 1 : 0;
            else m_c = 0;
            r = s & 255; m_z = (r == 0) ? 1 : 0; wr = 1;
        end else if (ir[17:15] == 3'b110) begin
            r = a; m_c = 0;
            for (int i = 0; i < int'(ir[7:5]); i++) begin
                case (ir[1:0])
                    2'd0: begin m_c = (r >> 7) & 1; r = (r << 1) & 255; end
                    2'd1: begin m_c = r & 1; r = r >> 1; end
                    2'd2: begin m_c = (r >> 7) & 1; r = ((r << 1) | m_c) & 255; end
                    default: begin m_c = r & 1; r = (r >> 1) | (m_c << 7); end
                endcase
            end
            m_z = (r == 0) ? 1 : 0; wr = 1;
        end else if (ir[17:16] == 2'b10) begin
            adr = (a + int'(ir[7:0])) % 256;
            case (ir[15:14])
                2'd0: begin push_ev(1, adr, 0, 0); r = m_dmem[adr]; wr = 1; end
                2'd1: begin push_ev(1, adr, 1, m_r[rd]); m_dmem[adr] = m_r[rd]; end
                2'd2: begin push_ev(2, adr, 0, 0); r = int'(port_rd(8'(adr))); wr = 1; end
                default: push_ev(2, adr, 1, m_r[rd]);
            endcase
        end else if (ir[17:12] == 6'b111110) begin
            case (ir[11:10])
                2'd0: taken = m_z;
                2'd1: taken = 1 - m_z;
                2'd2: taken = m_c;
                default: taken = 1 - m_c;
            endcase
            disp = int'(ir[7:0]);
            if (disp > 127) disp = disp - 256;
            if (taken != 0) npc = (m_pc + 1 + disp) & 4095;
        end else if (ir[17:13] == 5'b11110) begin
            if (ir[12]) begin m_stack[m_sp] = npc; m_sp = (m_sp + 1) % 8; end
            npc = ir[11:0];
        end else if (ir[17:11] == 7'b1111110 && ir[10:8] == 3'd0) begin
            m_sp = (m_sp + 7) % 8;
            npc  = m_stack[m_sp];
        end
        if (wr != 0 && rd != 0) m_r[rd] = r;
        m_pc = npc;
    endtask

    // Runs n instructions in the model plus the fetch of the next one, then
    // releases reset and waits (bounded) for the DUT to produce all of them.
    task automatic run_program(input int n, input string tag);
        model_reset();
        for (int i = 0; i < n; i++) model_step();
        push_ev(0, m_pc, 0, 0);
        fetch_log.delete(); fetch_cyc.delete();
        wr_count = 0; last_wr_adr = -1; last_wr_dat = -1;
        @(negedge clk); rst_i = 1'b0;
        for (int k = 0; k < 30000; k++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        check({tag, "_pending_events"}, exp_q.size(), 0);
        exp_q.delete();
        for (int i = 1; i < 8; i++) check({tag, "_gpr"}, int'(dut.GPR[i]), m_r[i]);
        check({tag, "_z"}, int'(dut.z_q), m_z);
        check({tag, "_c"}, int'(dut.c_q), m_c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_inst_cyc"}, int'(inst_cyc_o), 0);
        check({tag, "_inst_stb"}, int'(inst_stb_o), 0);
        check({tag, "_inst_adr"}, int'(inst_adr_o), 0);
        check({tag, "_data_cyc_stb_we"}, int'({data_cyc_o, data_stb_o, data_we_o}), 0);
        check({tag, "_data_adr_dat"}, int'({data_adr_o, data_dat_o}), 0);
        check({tag, "_port_cyc_stb_we"}, int'({port_cyc_o, port_stb_o, port_we_o}), 0);
        check({tag, "_port_adr_dat"}, int'({port_adr_o, port_dat_o}), 0);
        check({tag, "_int_ack"}, int'(int_ack), 0);
    endtask

    task automatic gen_random_program();
        for (int a = 0; a < 4096; a++) begin
            int cls;
            logic [17:0] w;
            cls = $urandom_range(0, 11);
            w   = 18'($urandom);
            case (cls)
                0, 1, 2: w[17] = 1'b0;
                3, 4:    w[17:14] = 4'b1110;
                5:       w[17:15] = 3'b110;
                6, 7:    w[17:16] = 2'b10;
                8:       w[17:12] = 6'b111110;
                9:       w[17:13] = 5'b11110;
                10: begin
                    w[17:11] = 7'b1111110;
                    if ($urandom_range(0, 1) == 1) w[10:8] = 3'd0;
                end
                default: w[17:11] = 7'b1111111;
            endcase
            imem[a] = w;
        end
    endtask

    localparam int N_DIR = 14;
    int exp_fetch [N_DIR] = '{0, 1, 2, 3, 256, 4, 5, 6, 7, 8, 10, 9, 10, 11};

    initial begin
        int found;
        rst_i = 1'b1; int_req = 1'b0; stall_en = 1'b0;
        inst_gate = 1'b1; data_gate = 1'b1; port_gate = 1'b1;
        for (int i = 0; i < 4096; i++) imem[i] = 18'h00000;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

        // Reset state while rst_i is held.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Directed program.
        imem[0]     = 18'h0080A;  // addi r1,r0,10
        imem[1]     = 18'h24805;  // stm  r1,(r0)+5
        imem[2]     = 18'h22005;  // ldm  r4,(r0)+5
        imem[3]     = 18'h3D100;  // jsb  0x100
        imem[12'h100] = 18'h3F000; // ret
        imem[4]     = 18'h008FF;  // addi r1,r0,0xFF
        imem[5]     = 18'h01101;  // addi r2,r1,1   -> 0, Z=1 C=1
        imem[6]     = 18'h09801;  // subi r3,r0,1   -> FF, C=1
        imem[7]     = 18'h03000;  // addi r6,r0,0   -> Z=1
        imem[8]     = 18'h3C00A;  // jmp  10
        imem[9]     = 18'h03801;  // addi r7,r0,1   -> Z=0
        imem[10]    = 18'h3E0FE;  // bz   -2
        imem[11]    = 18'h3C00B;  // jmp  11
        run_program(N_DIR, "directed");
        for (int i = 0; i < N_DIR; i++)
            check("directed_fetch_adr", (fetch_log.size() > i) ? fetch_log[i] : -1, exp_fetch[i]);
        check("alu_cycles",  (fetch_cyc.size() > 1) ? fetch_cyc[1] - fetch_cyc[0] : -1, 2);
        check("stm_cycles",  (fetch_cyc.size() > 2) ? fetch_cyc[2] - fetch_cyc[1] : -1, 3);
        check("ldm_cycles",  (fetch_cyc.size() > 3) ? fetch_cyc[3] - fetch_cyc[2] : -1, 3);
        check("r1_ff",   int'(dut.GPR[1]), 8'hFF);
        check("r2_wrap", int'(dut.GPR[2]), 8'h00);
        check("r3_sub",  int'(dut.GPR[3]), 8'hFF);
        check("r4_ldm",  int'(dut.GPR[4]), 8'h0A);
        check("r7",      int'(dut.GPR[7]), 8'h01);
        check("data_write_count", wr_count, 1);
        check("data_write_adr",   last_wr_adr, 5);
        check("data_write_dat",   last_wr_dat, 8'h0A);

        // Reset during a data cycle that is never acknowledged.
        @(negedge clk); rst_i = 1'b1;
        imem[0]   = 18'h20833;   // ldm r1,(r0)+0x33
        data_gate = 1'b0;
        @(negedge clk); rst_i = 1'b0;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (data_cyc_o) begin found = 1; break; end
        end
        check("held_data_cyc_seen", found, 1);
        check("held_data_adr", int'(data_adr_o), 8'h33);
        repeat (2) @(negedge clk);
        check("held_data_still_cyc", int'(data_cyc_o), 1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        data_gate = 1'b1;

        // Randomized programs with random bus stalls.
        for (int run = 0; run < 3; run++) begin
            @(negedge clk); rst_i = 1'b1;
            gen_random_program();
            for (int i = 0; i < 256; i++) dmem[i] = 8'($urandom);
            stall_en = (run != 0);
            @(posedge clk);
            run_program(350, "random");
            stall_en = 1'b0;
            @(posedge clk); #3;
            inst_gate = 1'b1; data_gate = 1'b1; port_gate = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
